// File: rtl/alu_wb_queue.sv
// Writeback queue behind the 1-cycle ALU: pairs each destination with its result, buffers it, drains to the register file.
// Optional feature macro: ALU_WB_FLAGS_EN (zero/negative flags of the last committed result).
module alu_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int RW    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [RW-1:0]                issue_rd,
  output logic                         issue_ready,
  input  logic signed [DW-1:0]         alu_out,
  output logic                         wb_valid,
  output logic [RW-1:0]                wb_rd,
  output logic [DW-1:0]                wb_data,
  input  logic                         wb_ready,
  output logic                         flag_z,
  output logic                         flag_n,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic                 s1_vld_q, s1_vld_d;
  logic [RW-1:0]        s1_rd_q;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [RW-1:0]        mem_rd_q   [DEPTH];
  logic signed [DW-1:0] mem_data_q [DEPTH];
  logic                 push, pop;
  logic [CW:0]          occ;

  assign wb_valid = (count_q != '0);
  assign wb_rd    = wb_valid ? mem_rd_q[rd_ptr_q] : '0;
  assign wb_data  = wb_valid ? mem_data_q[rd_ptr_q] : '0;
  assign count    = count_q;

  // In-flight op reserves a slot so its result always has room one cycle later.
  assign occ         = {1'b0, count_q} + {{CW{1'b0}}, s1_vld_q};
  assign issue_ready = (occ < (CW+1)'(DEPTH));

  always_comb begin
    push     = s1_vld_q && (s1_rd_q != '0);
    pop      = wb_valid && wb_ready;
    s1_vld_d = issue_valid && issue_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
    if (pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
    case ({push, pop})
      2'b10:   count_d = CW'(count_q + 1'b1);
      2'b01:   count_d = CW'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  // Stage 1 boundary: issue -> result pairing; FIFO control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath storage carries no reset; the empty-mux hides stale contents.
  always_ff @(posedge clk) begin
    s1_rd_q <= issue_rd;
    if (push && !rst) begin
      mem_rd_q[wr_ptr_q]   <= s1_rd_q;
      mem_data_q[wr_ptr_q] <= alu_out;
    end
  end

`ifdef ALU_WB_FLAGS_EN
  logic flag_z_q, flag_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (pop) begin
      flag_z_q <= (wb_data == '0);
      flag_n_q <= wb_data[DW-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wb_queue.sv
// Bench for alu_wb_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_alu_wb_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int RW    = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                issue_valid = 1'b0;
  logic [RW-1:0]       issue_rd = '0;
  logic                issue_ready;
  logic signed [DW-1:0] alu_out = '0;
  logic                wb_valid;
  logic [RW-1:0]       wb_rd;
  logic [DW-1:0]       wb_data;
  logic                wb_ready = 1'b0;
  logic                flag_z, flag_n;
  logic [CW-1:0]       count;

  alu_wb_queue #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .flag_z(flag_z), .flag_n(flag_n), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: committed entries as a plain queue, plus the one op waiting on the ALU.
  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            pend_v = 0;
  logic [RW-1:0] pend_rd = '0;
  bit            m_z = 0, m_n = 0;

  // Checks current outputs against the model, applies inputs over one edge, advances the model.
  task automatic do_cycle(input bit iv, input logic [RW-1:0] ird, input logic [DW-1:0] aout,
                          input bit wr, input bit r);
    bit   exp_rdy;
    ent_t e;
    issue_valid = iv;
    issue_rd    = ird;
    alu_out     = aout;
    wb_ready    = wr;
    rst         = r;
    exp_rdy = (mq.size() + int'(pend_v)) < DEPTH;
    chk("issue_ready", 32'(issue_ready), 32'(exp_rdy));
    chk("count", 32'(count), 32'(mq.size()));
    chk("wb_valid", 32'(wb_valid), 32'(mq.size() != 0));
    chk("wb_rd", 32'(wb_rd), (mq.size() != 0) ? 32'(mq[0].rd) : 32'd0);
    chk("wb_data", 32'(wb_data), (mq.size() != 0) ? 32'(mq[0].d) : 32'd0);
`ifdef ALU_WB_FLAGS_EN
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("flag_n", 32'(flag_n), 32'(m_n));
`else
    chk("flag_z", 32'(flag_z), 32'd0);
    chk("flag_n", 32'(flag_n), 32'd0);
`endif
    if (r) begin
      mq.delete();
      pend_v = 0;
      m_z = 0;
      m_n = 0;
    end else begin
      if (mq.size() != 0 && wr) begin
        e = mq.pop_front();
        m_z = (e.d == '0);
        m_n = e.d[DW-1];
      end
      if (pend_v && pend_rd != '0) begin
        if (mq.size() >= DEPTH) chk("overflow", 32'(mq.size()), 32'(DEPTH - 1));
        e.rd = pend_rd;
        e.d  = aout;
        mq.push_back(e);
      end
      pend_v  = iv && exp_rdy;
      pend_rd = ird;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int acc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wbdata", 32'(wb_data), 32'd0);

    // Single op: rd=3, result 0x0002
    do_cycle(1, 3'd3, 16'h0000, 0, 0);
    do_cycle(0, 3'd0, 16'h0002, 0, 0);
    chk("t1_vld", 32'(wb_valid), 32'd1);
    chk("t1_rd", 32'(wb_rd), 32'd3);
    chk("t1_data", 32'(wb_data), 32'h0002);
    do_cycle(0, 3'd0, 16'h0000, 1, 0);
    chk("t1_cnt", 32'(count), 32'd0);
    chk("t1_z", 32'(flag_z), 32'd0);
    chk("t1_n", 32'(flag_n), 32'd0);

    // Flags: 0x8000 then 0x0000
    do_cycle(1, 3'd5, 16'h0000, 1, 0);
    do_cycle(1, 3'd2, 16'h8000, 1, 0);
    do_cycle(0, 3'd0, 16'h0000, 1, 0);
`ifdef ALU_WB_FLAGS_EN
    chk("t2_zn1", {30'd0, flag_z, flag_n}, 32'b01);
`else
    chk("t2_zn1", {30'd0, flag_z, flag_n}, 32'b00);
`endif
    do_cycle(0, 3'd0, 16'h0000, 1, 0);
`ifdef ALU_WB_FLAGS_EN
    chk("t2_zn2", {30'd0, flag_z, flag_n}, 32'b10);
`else
    chk("t2_zn2", {30'd0, flag_z, flag_n}, 32'b00);
`endif

    // Backpressure fill: exactly DEPTH ops accepted
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (issue_ready) acc++;
      do_cycle(1, 3'(i % 7 + 1), 16'(16'h1000 + i), 0, 0);
    end
    chk("t3_accepted", 32'(acc), 32'd4);
    chk("t3_cnt", 32'(count), 32'd4);
    chk("t3_ready", 32'(issue_ready), 32'd0);
    for (int i = 0; i < 5; i++) do_cycle(0, 3'd0, 16'h0000, 1, 0);
    chk("t3_empty", 32'(wb_valid), 32'd0);

    // r0 discard
    do_cycle(1, 3'd0, 16'h0000, 0, 0);
    do_cycle(0, 3'd0, 16'h1234, 0, 0);
    do_cycle(0, 3'd0, 16'h0000, 0, 0);
    chk("t4_cnt", 32'(count), 32'd0);
    chk("t4_vld", 32'(wb_valid), 32'd0);

    // Streaming with wrap
    for (int i = 0; i < 12; i++) begin
      do_cycle(1, 3'(i % 7 + 1), 16'($urandom), 1, 0);
      chk("t5_cnt_le1", 32'(count <= 1), 32'd1);
    end
    for (int i = 0; i < 3; i++) do_cycle(0, 3'd0, 16'($urandom), 1, 0);

    // Reset with 3 queued and one in flight
    for (int i = 0; i < 4; i++) do_cycle(1, 3'(i + 1), 16'(16'h00F0 + i), 0, 0);
    chk("t6_pre_cnt", 32'(count), 32'd3);
    do_cycle(0, 3'd0, 16'h0AAA, 0, 1);
    chk("t6_cnt", 32'(count), 32'd0);
    chk("t6_vld", 32'(wb_valid), 32'd0);
    chk("t6_data", 32'(wb_data), 32'd0);
    chk("t6_flags", {30'd0, flag_z, flag_n}, 32'd0);
    chk("t6_ready", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 3; i++) do_cycle(0, 3'd0, 16'h0BBB, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 6; i++) do_cycle(0, 3'd0, 16'h0000, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
